imem_load_arbiter: RTL and testbench
====================================

// Module: imem_load_arbiter
// PURPOSE
//  Shares the single instruction-memory port between the fetch stage and a program loader (UART/JTAG).
//  After reset it owns the port for loading, then releases it to fetch and restarts the PC at BOOT_ADDR.
//  A loader request while running drains the pipeline (hold + flush) before loading resumes.
//  Sits between fetch, the hazard unit (hold/flush OR-ed into StallF/FlushD) and instruction memory.
// PARAMETERS
//  IMEM_DEPTH    1024      instruction memory depth in 32-bit words (power of 2)
//  BOOT_ADDR     32'h0     byte address loaded into the PC on restart
//  DRAIN_CYCLES  4         hold cycles in DRAIN before the loader is granted (>=1)
// PORTS
//  clk             in   1   clock
//  rst             in   1   synchronous, active-high reset
//  fetch_req       in   1   fetch wants a read this cycle
//  fetch_addr      in   32  fetch byte address (PCF)
//  fetch_rdata     out  32  instruction read data, valid when fetch_valid
//  fetch_valid     out  1   read data valid, 1 cycle after the granted fetch_req
//  ld_valid        in   1   loader word valid
//  ld_ready        out  1   loader word accepted when ld_valid & ld_ready
//  ld_addr         in   32  loader byte address
//  ld_data         in   32  loader word
//  ld_last         in   1   final word of the image
//  ld_err          out  1   sticky: an accepted word had an out-of-range address
//  ld_count        out  $clog2(IMEM_DEPTH)+1  words accepted this load, saturating
//  ld_checksum     out  32  running sum of accepted words (see CONFIGURATION)
//  mem_en          out  1   memory access enable
//  mem_we          out  1   memory write enable
//  mem_addr        out  $clog2(IMEM_DEPTH)  word address
//  mem_wdata       out  32  write data
//  mem_rdata       in   32  synchronous read data (1-cycle latency)
//  core_hold       out  1   stall PC/IF-ID (to StallF)
//  core_flush      out  1   flush IF/ID (to FlushD)
//  pc_restart      out  1   1-cycle pulse: load PC with pc_restart_addr
//  pc_restart_addr out  32  always BOOT_ADDR
// BEHAVIOUR
//  States: LOAD, START, RUN, DRAIN. Registered outputs; reset -> LOAD, core_hold=1, core_flush=0,
//   pc_restart=0, fetch_valid=0, ld_err=0, ld_count=0, ld_checksum=0. ld_ready/mem_* are decoded from state.
//  LOAD: ld_ready=1, core_hold=1. Accepted word -> mem_en=1, mem_we=1, mem_addr=ld_addr[AW+1:2], ld_count+1.
//   ld_addr[1:0] ignored. ld_addr >= IMEM_DEPTH*4: word accepted, write suppressed, ld_err set.
//   Accepted word with ld_last -> write that word, then START. No fetch grant in LOAD.
//  START (1 cycle): pc_restart=1, core_flush=1, core_hold=1, ld_ready=0; -> RUN.
//  RUN: core_hold=0; mem_en=fetch_req, mem_we=0, mem_addr=fetch_addr[AW+1:2];
//   fetch_valid=registered fetch_req, fetch_rdata=mem_rdata. ld_ready=0.
//   ld_valid seen -> DRAIN; a fetch in the same cycle is still granted (fetch wins).
//  DRAIN: core_hold=1, core_flush=1, mem_en=0; counter runs DRAIN_CYCLES cycles, then LOAD.
//   Entering LOAD clears ld_count, ld_err and ld_checksum; the pending ld_valid word is accepted there.
//  ld_valid held while ld_ready=0 is not consumed; loader must hold data stable (valid/ready rules).
//  ld_count saturates at IMEM_DEPTH; no wrap.
//  rst at any state -> LOAD next cycle, partial load abandoned, memory contents untouched.
// CONFIGURATION
//  IMEM_CHECKSUM_EN defined: ld_checksum = mod-2^32 sum of ld_data of every accepted in-range word this load.
//  Not defined: ld_checksum tied to 32'h0, no adder synthesised.
// STRUCTURE
//  Shared header imem_arb_defs.vh: state encodings (LOAD=2'd0, START=2'd1, RUN=2'd2, DRAIN=2'd3).
//  BOOT_ADDR default also lives there (shared with PC reset).
//  Sub-module load_checksum (accumulator, clear/enable) instantiated only under IMEM_CHECKSUM_EN.
// TESTING
//  Reset, load 3 words @0,4,8 (last on 3rd) -> 3 writes, ld_count=3; then pc_restart=1 one cycle, RUN.
//  RUN, fetch_req=1, fetch_addr=0x8 -> mem_addr=2, fetch_valid=1 next cycle with mem_rdata.
//  RUN, ld_valid=1 with fetch_req=1 same cycle -> fetch granted; DRAIN 4 cycles (hold+flush); LOAD; word accepted.
//  LOAD, ld_addr=0x1000 with IMEM_DEPTH=1024 -> no mem_we, ld_err=1, ld_count increments.
//  rst mid-LOAD after 2 words -> LOAD, ld_count=0, ld_err=0, core_hold=1.
//  IMEM_CHECKSUM_EN: load 0x1,0xFFFFFFFF,0x5 -> ld_checksum=0x5; undefined -> 0x0.

Source files
------------

// File: rtl/imem_load_arbiter_pkg.sv
// Shared definitions for the instruction-memory load arbiter.
// State encodings are fixed so other units (debug, trace) can decode them,
// and the boot address default is shared with the PC reset value.
package imem_load_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_START = 2'd1,
        ST_RUN   = 2'd2,
        ST_DRAIN = 2'd3
    } arb_state_e;

    localparam logic [31:0] BOOT_ADDR_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/imem_load_arbiter_load_checksum.sv
// Running mod-2^32 accumulator over loaded image words.
// Only exists when IMEM_CHECKSUM_EN is defined; otherwise no adder is built.
`ifdef IMEM_CHECKSUM_EN
module imem_load_arbiter_load_checksum (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        enable,
    input  logic [31:0] data,
    output logic [31:0] sum
);

    logic [31:0] sum_q;
    logic [31:0] sum_d;

    // Clear wins over accumulate so a new load always starts from zero
    always_comb begin
        sum_d = sum_q;
        if (clear) begin
            sum_d = 32'h0;
        end else if (enable) begin
            sum_d = sum_q + data;
        end
    end

    // Accumulator register
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q <= 32'h0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign sum = sum_q;

endmodule
`endif

// File: rtl/imem_load_arbiter.sv
// Shares the single instruction-memory port between fetch and a program loader.
// Owns the port for loading after reset, then restarts the PC and hands the
// port to fetch; a loader request while running drains the pipeline first.
// Optional feature macro: IMEM_CHECKSUM_EN (running checksum of loaded words).
module imem_load_arbiter
    import imem_load_arbiter_pkg::*;
#(
    parameter int          IMEM_DEPTH   = 1024,
    parameter logic [31:0] BOOT_ADDR    = BOOT_ADDR_DEFAULT,
    parameter int          DRAIN_CYCLES = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          fetch_req,
    input  logic [31:0]                   fetch_addr,
    output logic [31:0]                   fetch_rdata,
    output logic                          fetch_valid,
    input  logic                          ld_valid,
    output logic                          ld_ready,
    input  logic [31:0]                   ld_addr,
    input  logic [31:0]                   ld_data,
    input  logic                          ld_last,
    output logic                          ld_err,
    output logic [$clog2(IMEM_DEPTH):0]   ld_count,
    output logic [31:0]                   ld_checksum,
    output logic                          mem_en,
    output logic                          mem_we,
    output logic [$clog2(IMEM_DEPTH)-1:0] mem_addr,
    output logic [31:0]                   mem_wdata,
    input  logic [31:0]                   mem_rdata,
    output logic                          core_hold,
    output logic                          core_flush,
    output logic                          pc_restart,
    output logic [31:0]                   pc_restart_addr
);

    localparam int AW  = $clog2(IMEM_DEPTH);
    localparam int CW  = AW + 1;
    localparam int DCW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    arb_state_e       state_q, state_d;
    logic [DCW-1:0]   drain_cnt_q, drain_cnt_d;
    logic [CW-1:0]    ld_count_q, ld_count_d;
    logic             ld_err_q, ld_err_d;
    logic             core_hold_q, core_hold_d;
    logic             core_flush_q, core_flush_d;
    logic             pc_restart_q, pc_restart_d;
    logic             fetch_valid_q, fetch_valid_d;

    logic             ld_accept;
    logic             ld_in_range;
    logic             unused_addr_bits;

    assign ld_ready    = (state_q == ST_LOAD);
    assign ld_accept   = ld_valid && ld_ready;
    assign ld_in_range = (ld_addr[31:AW+2] == '0);

    // Byte offsets and fetch address bits beyond the memory are don't-care
    assign unused_addr_bits = ^{fetch_addr[31:AW+2], fetch_addr[1:0], ld_addr[1:0]};

    // Next-state, load bookkeeping and drain counter
    always_comb begin
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        ld_count_d  = ld_count_q;
        ld_err_d    = ld_err_q;
        case (state_q)
            ST_LOAD: begin
                if (ld_accept) begin
                    if (ld_count_q != CW'(IMEM_DEPTH)) begin
                        ld_count_d = ld_count_q + CW'(1);
                    end
                    if (!ld_in_range) begin
                        ld_err_d = 1'b1;
                    end
                    if (ld_last) begin
                        state_d = ST_START;
                    end
                end
            end
            ST_START: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (ld_valid) begin
                    state_d     = ST_DRAIN;
                    drain_cnt_d = '0;
                end
            end
            ST_DRAIN: begin
                if (drain_cnt_q == DCW'(DRAIN_CYCLES - 1)) begin
                    state_d    = ST_LOAD;
                    ld_count_d = '0;
                    ld_err_d   = 1'b0;
                end else begin
                    drain_cnt_d = drain_cnt_q + DCW'(1);
                end
            end
            default: begin
                state_d = ST_LOAD;
            end
        endcase
    end

    // Core-control outputs are precomputed from the next state so they are registered
    always_comb begin
        core_hold_d   = (state_d != ST_RUN);
        core_flush_d  = (state_d == ST_START) || (state_d == ST_DRAIN);
        pc_restart_d  = (state_d == ST_START);
        fetch_valid_d = (state_q == ST_RUN) && fetch_req;
    end

    // Memory port steering: loader writes in LOAD, fetch reads in RUN, idle otherwise
    always_comb begin
        mem_en   = 1'b0;
        mem_we   = 1'b0;
        mem_addr = '0;
        case (state_q)
            ST_LOAD: begin
                mem_addr = ld_addr[AW+1:2];
                if (ld_accept && ld_in_range) begin
                    mem_en = 1'b1;
                    mem_we = 1'b1;
                end
            end
            ST_RUN: begin
                mem_en   = fetch_req;
                mem_addr = fetch_addr[AW+1:2];
            end
            default: begin
                mem_en = 1'b0;
            end
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_LOAD;
            drain_cnt_q   <= '0;
            ld_count_q    <= '0;
            ld_err_q      <= 1'b0;
            core_hold_q   <= 1'b1;
            core_flush_q  <= 1'b0;
            pc_restart_q  <= 1'b0;
            fetch_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            drain_cnt_q   <= drain_cnt_d;
            ld_count_q    <= ld_count_d;
            ld_err_q      <= ld_err_d;
            core_hold_q   <= core_hold_d;
            core_flush_q  <= core_flush_d;
            pc_restart_q  <= pc_restart_d;
            fetch_valid_q <= fetch_valid_d;
        end
    end

`ifdef IMEM_CHECKSUM_EN
    logic checksum_clear;
    logic checksum_en;

    assign checksum_clear = (state_q == ST_DRAIN) && (state_d == ST_LOAD);
    assign checksum_en    = ld_accept && ld_in_range;

    imem_load_arbiter_load_checksum u_load_checksum (
        .clk    (clk),
        .rst    (rst),
        .clear  (checksum_clear),
        .enable (checksum_en),
        .data   (ld_data),
        .sum    (ld_checksum)
    );
`else
    assign ld_checksum = 32'h0;
`endif

    assign fetch_rdata     = mem_rdata;
    assign fetch_valid     = fetch_valid_q;
    assign mem_wdata       = ld_data;
    assign ld_err          = ld_err_q;
    assign ld_count        = ld_count_q;
    assign core_hold       = core_hold_q;
    assign core_flush      = core_flush_q;
    assign pc_restart      = pc_restart_q;
    assign pc_restart_addr = BOOT_ADDR;

endmodule

// File: tb/tb_imem_load_arbiter.sv
// Directed testbench for imem_load_arbiter with a behavioural 1-cycle-latency memory.
// Expected checksum values depend on IMEM_CHECKSUM_EN.
module tb_imem_load_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_req;
    logic [31:0] fetch_addr;
    logic [31:0] fetch_rdata;
    logic        fetch_valid;
    logic        ld_valid;
    logic        ld_ready;
    logic [31:0] ld_addr;
    logic [31:0] ld_data;
    logic        ld_last;
    logic        ld_err;
    logic [10:0] ld_count;
    logic [31:0] ld_checksum;
    logic        mem_en;
    logic        mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        core_hold;
    logic        core_flush;
    logic        pc_restart;
    logic [31:0] pc_restart_addr;

    int checkCount = 0;
    int errorCount = 0;

    logic [31:0] memArray [0:1023];

    imem_load_arbiter #(
        .IMEM_DEPTH   (1024),
        .BOOT_ADDR    (32'h0),
        .DRAIN_CYCLES (4)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .fetch_req       (fetch_req),
        .fetch_addr      (fetch_addr),
        .fetch_rdata     (fetch_rdata),
        .fetch_valid     (fetch_valid),
        .ld_valid        (ld_valid),
        .ld_ready        (ld_ready),
        .ld_addr         (ld_addr),
        .ld_data         (ld_data),
        .ld_last         (ld_last),
        .ld_err          (ld_err),
        .ld_count        (ld_count),
        .ld_checksum     (ld_checksum),
        .mem_en          (mem_en),
        .mem_we          (mem_we),
        .mem_addr        (mem_addr),
        .mem_wdata       (mem_wdata),
        .mem_rdata       (mem_rdata),
        .core_hold       (core_hold),
        .core_flush      (core_flush),
        .pc_restart      (pc_restart),
        .pc_restart_addr (pc_restart_addr)
    );

    always #5 clk = ~clk;

    // Synchronous instruction memory with one cycle of read latency
    always @(posedge clk) begin
        if (mem_en && mem_we) begin
            memArray[mem_addr] <= mem_wdata;
        end
        if (mem_en && !mem_we) begin
            mem_rdata <= memArray[mem_addr];
        end
    end

    function automatic logic [31:0] expSum(input logic [31:0] v);
`ifdef IMEM_CHECKSUM_EN
        return v;
`else
        return 32'h0 & v;
`endif
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic req, input logic [31:0] faddr, input logic lv,
                                 input logic [31:0] la, input logic [31:0] ldat, input logic last);
        @(negedge clk);
        fetch_req  = req;
        fetch_addr = faddr;
        ld_valid   = lv;
        ld_addr    = la;
        ld_data    = ldat;
        ld_last    = last;
        #1;
    endtask

    initial begin
        rst        = 1'b1;
        fetch_req  = 1'b0;
        fetch_addr = 32'h0;
        ld_valid   = 1'b0;
        ld_addr    = 32'h0;
        ld_data    = 32'h0;
        ld_last    = 1'b0;
        mem_rdata  = 32'h0;
        repeat (2) @(posedge clk);

        // Reset state
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
        checkOutput("rst_hold",     32'(core_hold),   32'h1);
        checkOutput("rst_flush",    32'(core_flush),  32'h0);
        checkOutput("rst_restart",  32'(pc_restart),  32'h0);
        checkOutput("rst_fvalid",   32'(fetch_valid), 32'h0);
        checkOutput("rst_err",      32'(ld_err),      32'h0);
        checkOutput("rst_count",    32'(ld_count),    32'h0);
        checkOutput("rst_checksum", ld_checksum,      32'h0);
        checkOutput("rst_ready",    32'(ld_ready),    32'h1);
        rst = 1'b0;

        // Load three words at 0, 4, 8
        applyStimulus(1'b0, 32'h0, 1'b1, 32'h0, 32'h0000_0001, 1'b0);
        checkOutput("w0_en",   32'(mem_en),   32'h1);
        checkOutput("w0_we",   32'(mem_we),   32'h1);
        checkOutput("w0_addr", 32'(mem_addr), 32'h0);
        applyStimulus(1'b0, 32'h0, 1'b1, 32'h4, 32'hFFFF_FFFF, 1'b0);
        checkOutput("w1_addr",  32'(mem_addr), 32'h1);
        checkOutput("w1_count", 32'(ld_count), 32'h1);
        applyStimulus(1'b0, 32'h0, 1'b1, 32'h8, 32'h0000_0005, 1'b1);
        checkOutput("w2_we",    32'(mem_we),   32'h1);
        checkOutput("w2_addr",  32'(mem_addr), 32'h2);
        checkOutput("w2_count", 32'(ld_count), 32'h2);

        // START
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
        checkOutput("start_restart", 32'(pc_restart), 32'h1);
        checkOutput("start_flush",   32'(core_flush), 32'h1);
        checkOutput("start_hold",    32'(core_hold),  32'h1);
        checkOutput("start_ready",   32'(ld_ready),   32'h0);
        checkOutput("start_count",   32'(ld_count),   32'h3);
        checkOutput("start_sum",     ld_checksum,     expSum(32'h5));
        checkOutput("start_paddr",   pc_restart_addr, 32'h0);
        checkOutput("start_men",     32'(mem_en),     32'h0);

        // RUN, fetch from 0x8
        applyStimulus(1'b1, 32'h8, 1'b0, 32'h0, 32'h0, 1'b0);
        checkOutput("run_restart", 32'(pc_restart), 32'h0);
        checkOutput("run_hold",    32'(core_hold),  32'h0);
        checkOutput("run_flush",   32'(core_flush), 32'h0);
        checkOutput("run_men",     32'(mem_en),     32'h1);
        checkOutput("run_mwe",     32'(mem_we),     32'h0);
        checkOutput("run_maddr",   32'(mem_addr),   32'h2);

        // Loader request with a simultaneous fetch: fetch still granted
        applyStimulus(1'b1, 32'h4, 1'b1, 32'hC, 32'hA5A5_A5A5, 1'b1);
        checkOutput("f8_valid", 32'(fetch_valid), 32'h1);
        checkOutput("f8_rdata", fetch_rdata,      32'h0000_0005);
        checkOutput("race_men",   32'(mem_en),   32'h1);
        checkOutput("race_maddr", 32'(mem_addr), 32'h1);
        checkOutput("race_ready", 32'(ld_ready), 32'h0);

        // DRAIN for four cycles
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 32'h0, 1'b1, 32'hC, 32'hA5A5_A5A5, 1'b1);
            checkOutput("drain_hold",  32'(core_hold),  32'h1);
            checkOutput("drain_flush", 32'(core_flush), 32'h1);
            checkOutput("drain_men",   32'(mem_en),     32'h0);
            checkOutput("drain_ready", 32'(ld_ready),   32'h0);
            if (i == 0) begin
                checkOutput("f4_valid", 32'(fetch_valid), 32'h1);
                checkOutput("f4_rdata", fetch_rdata,      32'hFFFF_FFFF);
            end
        end

        // Back in LOAD: pending word accepted, bookkeeping cleared
        applyStimulus(1'b0, 32'h0, 1'b1, 32'hC, 32'hA5A5_A5A5, 1'b1);
        checkOutput("reload_ready", 32'(ld_ready),    32'h1);
        checkOutput("reload_hold",  32'(core_hold),   32'h1);
        checkOutput("reload_flush", 32'(core_flush),  32'h0);
        checkOutput("reload_count", 32'(ld_count),    32'h0);
        checkOutput("reload_err",   32'(ld_err),      32'h0);
        checkOutput("reload_sum",   ld_checksum,      32'h0);
        checkOutput("reload_we",    32'(mem_we),      32'h1);
        checkOutput("reload_addr",  32'(mem_addr),    32'h3);
        checkOutput("reload_fval",  32'(fetch_valid), 32'h0);

        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
        checkOutput("start2_count",   32'(ld_count),   32'h1);
        checkOutput("start2_sum",     ld_checksum,     expSum(32'hA5A5_A5A5));
        checkOutput("start2_restart", 32'(pc_restart), 32'h1);

        // Reset while running
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
        rst = 1'b1;
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
        rst = 1'b0;
        checkOutput("rst2_ready", 32'(ld_ready),  32'h1);
        checkOutput("rst2_hold",  32'(core_hold), 32'h1);
        checkOutput("rst2_count", 32'(ld_count),  32'h0);

        // Out-of-range word: accepted, no write, error flagged
        applyStimulus(1'b0, 32'h0, 1'b1, 32'h1000, 32'hDEAD_BEEF, 1'b0);
        checkOutput("oor_we", 32'(mem_we), 32'h0);
        checkOutput("oor_en", 32'(mem_en), 32'h0);
        applyStimulus(1'b0, 32'h0, 1'b1, 32'h10, 32'h0000_0077, 1'b0);
        checkOutput("oor_err",   32'(ld_err),   32'h1);
        checkOutput("oor_count", 32'(ld_count), 32'h1);
        checkOutput("w10_we",    32'(mem_we),   32'h1);
        checkOutput("w10_addr",  32'(mem_addr), 32'h4);
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
        checkOutput("mid_count", 32'(ld_count), 32'h2);
        checkOutput("mid_err",   32'(ld_err),   32'h1);
        checkOutput("mid_sum",   ld_checksum,   expSum(32'h77));

        // Reset in the middle of a load
        rst = 1'b1;
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
        rst = 1'b0;
        checkOutput("rst3_count", 32'(ld_count),  32'h0);
        checkOutput("rst3_err",   32'(ld_err),    32'h0);
        checkOutput("rst3_hold",  32'(core_hold), 32'h1);
        checkOutput("rst3_ready", 32'(ld_ready),  32'h1);
        checkOutput("rst3_sum",   ld_checksum,    32'h0);

        // Fresh load, then fetch the word written before the reset
        applyStimulus(1'b0, 32'h0, 1'b1, 32'h14, 32'h0000_0099, 1'b1);
        checkOutput("w14_we",   32'(mem_we),   32'h1);
        checkOutput("w14_addr", 32'(mem_addr), 32'h5);
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
        checkOutput("start3_count", 32'(ld_count), 32'h1);
        checkOutput("start3_sum",   ld_checksum,   expSum(32'h99));
        applyStimulus(1'b1, 32'h10, 1'b0, 32'h0, 32'h0, 1'b0);
        checkOutput("run3_maddr", 32'(mem_addr), 32'h4);
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
        checkOutput("f10_valid", 32'(fetch_valid), 32'h1);
        checkOutput("f10_rdata", fetch_rdata,      32'h0000_0077);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
